// File: rtl/trdb_pkg.sv
// trdb_pkg: shared widths and filter-register map for the trace debugger.
// Holds the data widths used by the trace encoder, the byte offsets of the
// filter configuration registers, the filter group index and the commit
// FSM state encoding.
package trdb_pkg;

   localparam int XLEN      = 32;
   localparam int CAUSE_LEN = 5;
   localparam int PRIV_LEN  = 2;

   // Filter register map (byte offsets, word aligned)
   localparam logic [7:0] FREG_CTRL     = 8'h00;
   localparam logic [7:0] FREG_UPPER    = 8'h04;
   localparam logic [7:0] FREG_LOWER    = 8'h08;
   localparam logic [7:0] FREG_MATCH    = 8'h0C;
   localparam logic [7:0] FREG_COMMIT   = 8'h50;
   localparam logic [7:0] FREG_STATUS   = 8'h54;
   localparam logic [7:0] FGROUP_STRIDE = 8'h10;

   typedef enum logic [2:0] {
      FG_CAUSE = 3'd0,
      FG_TVEC  = 3'd1,
      FG_TVAL  = 3'd2,
      FG_PRIV  = 3'd3,
      FG_IADDR = 3'd4
   } fgroup_e;

   typedef enum logic {
      CS_IDLE    = 1'b0,
      CS_PENDING = 1'b1
   } commit_state_e;

endpackage

// File: rtl/trdb_filter_cfg_group.sv
// trdb_filter_cfg_group: shadow and active copies of one filter group.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   we_i, sel_i         shadow write enable and register select (0 CTRL,
//                       1 UPPER, 2 LOWER, 3 MATCH)
//   ctrl_wdata_i        CTRL bits {equal_mode, range_mode, filter}
//   fld_wdata_i         bound value for UPPER/LOWER/MATCH
//   apply_i             copy shadow into active on this edge
//   ctrl_rd_o, fld_rd_o shadow read-back (fld_rd_o is 0 when CTRL selected)
//   filter_o .. match_o active configuration driving the filter
module trdb_filter_cfg_group
   import trdb_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         we_i,
   input  logic [1:0]   sel_i,
   input  logic [2:0]   ctrl_wdata_i,
   input  logic [W-1:0] fld_wdata_i,
   input  logic         apply_i,
   output logic [2:0]   ctrl_rd_o,
   output logic [W-1:0] fld_rd_o,
   output logic         filter_o,
   output logic         range_mode_o,
   output logic         equal_mode_o,
   output logic [W-1:0] upper_o,
   output logic [W-1:0] lower_o,
   output logic [W-1:0] match_o
);

   localparam logic [1:0] SEL_CTRL  = FREG_CTRL[3:2];
   localparam logic [1:0] SEL_UPPER = FREG_UPPER[3:2];
   localparam logic [1:0] SEL_LOWER = FREG_LOWER[3:2];
   localparam logic [1:0] SEL_MATCH = FREG_MATCH[3:2];

   logic [2:0]   ctrl_sh_reg, ctrl_act_reg;
   logic [W-1:0] upper_sh_reg, lower_sh_reg, match_sh_reg;
   logic [W-1:0] upper_act_reg, lower_act_reg, match_act_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_sh_reg   <= '0;
         upper_sh_reg  <= '0;
         lower_sh_reg  <= '0;
         match_sh_reg  <= '0;
         ctrl_act_reg  <= '0;
         upper_act_reg <= '0;
         lower_act_reg <= '0;
         match_act_reg <= '0;
      end else begin
         // The top never asserts we_i and apply_i together: shadow writes
         // are refused while a commit is pending.
         if (we_i) begin
            case (sel_i)
               SEL_CTRL:  ctrl_sh_reg  <= ctrl_wdata_i;
               SEL_UPPER: upper_sh_reg <= fld_wdata_i;
               SEL_LOWER: lower_sh_reg <= fld_wdata_i;
               SEL_MATCH: match_sh_reg <= fld_wdata_i;
               default:   ;
            endcase
         end
         if (apply_i) begin
            ctrl_act_reg  <= ctrl_sh_reg;
            upper_act_reg <= upper_sh_reg;
            lower_act_reg <= lower_sh_reg;
            match_act_reg <= match_sh_reg;
         end
      end
   end

   always_comb begin
      fld_rd_o = '0;
      case (sel_i)
         SEL_UPPER: fld_rd_o = upper_sh_reg;
         SEL_LOWER: fld_rd_o = lower_sh_reg;
         SEL_MATCH: fld_rd_o = match_sh_reg;
         default:   fld_rd_o = '0;
      endcase
   end

   assign ctrl_rd_o    = ctrl_sh_reg;
   assign filter_o     = ctrl_act_reg[0];
   assign range_mode_o = ctrl_act_reg[1];
   assign equal_mode_o = ctrl_act_reg[2];
   assign upper_o      = upper_act_reg;
   assign lower_o      = lower_act_reg;
   assign match_o      = match_act_reg;

endmodule

// File: rtl/trdb_filter_regs.sv
// trdb_filter_regs: APB register slave programming trdb_filter.
// Software writes a shadow copy; a COMMIT write arms a transfer into the
// active copy, which happens on the first edge the encoder reports idle.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   psel_i..pwdata_i, prdata_o,
//   pready_o, pslverr_o             zero-wait-state APB slave
//   idle_i                          encoder idle, commit may be applied
//   commit_pending_o, commit_done_o commit status / one-cycle done pulse
//   <g>_filter_o .. match_<g>_o     active configuration per group
module trdb_filter_regs
   import trdb_pkg::*;
#(
   parameter int APB_ADDR_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic [XLEN-1:0]       pwdata_i,
   output logic [XLEN-1:0]       prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   input  logic                  idle_i,
   output logic                  commit_pending_o,
   output logic                  commit_done_o,
   output logic                  cause_filter_o,
   output logic                  cause_range_mode_o,
   output logic                  cause_equal_mode_o,
   output logic [CAUSE_LEN-1:0]  upper_cause_o,
   output logic [CAUSE_LEN-1:0]  lower_cause_o,
   output logic [CAUSE_LEN-1:0]  match_cause_o,
   output logic                  tvec_filter_o,
   output logic                  tvec_range_mode_o,
   output logic                  tvec_equal_mode_o,
   output logic [XLEN-1:2]       upper_tvec_o,
   output logic [XLEN-1:2]       lower_tvec_o,
   output logic [XLEN-1:2]       match_tvec_o,
   output logic                  tval_filter_o,
   output logic                  tval_range_mode_o,
   output logic                  tval_equal_mode_o,
   output logic [XLEN-1:0]       upper_tval_o,
   output logic [XLEN-1:0]       lower_tval_o,
   output logic [XLEN-1:0]       match_tval_o,
   output logic                  priv_lvl_filter_o,
   output logic                  priv_lvl_range_mode_o,
   output logic                  priv_lvl_equal_mode_o,
   output logic [PRIV_LEN-1:0]   upper_priv_lvl_o,
   output logic [PRIV_LEN-1:0]   lower_priv_lvl_o,
   output logic [PRIV_LEN-1:0]   match_priv_lvl_o,
   output logic                  iaddr_filter_o,
   output logic                  iaddr_range_mode_o,
   output logic                  iaddr_equal_mode_o,
   output logic [XLEN-1:0]       upper_iaddr_o,
   output logic [XLEN-1:0]       lower_iaddr_o,
   output logic [XLEN-1:0]       match_iaddr_o
);

   commit_state_e state_reg;
   logic          done_reg;

   logic access, grp_hit, commit_hit, status_hit, mapped, pending;
   logic err, wr_ok, commit_req, apply;
   logic [4:0] grp_we;
   logic [1:0] sel;
   fgroup_e    grp;

   logic [2:0]           ctrl_rd [5];
   logic [CAUSE_LEN-1:0] cause_rd;
   logic [XLEN-1:2]      tvec_rd;
   logic [XLEN-1:0]      tval_rd, iaddr_rd;
   logic [PRIV_LEN-1:0]  priv_rd;

   assign access     = psel_i & penable_i;
   // Group registers occupy every aligned word below COMMIT.
   assign grp_hit    = (paddr_i[1:0] == 2'b00) && (paddr_i < APB_ADDR_W'(FREG_COMMIT));
   assign commit_hit = (paddr_i == APB_ADDR_W'(FREG_COMMIT));
   assign status_hit = (paddr_i == APB_ADDR_W'(FREG_STATUS));
   assign mapped     = grp_hit | commit_hit | status_hit;
   assign pending    = (state_reg == CS_PENDING);
   assign grp        = fgroup_e'(paddr_i[6:4]);
   assign sel        = paddr_i[3:2];

   // Shadow writes are refused while pending so the snapshot stays frozen;
   // a COMMIT write while pending is silently dropped, not an error.
   assign err        = ~mapped | (pwrite_i & status_hit) | (pwrite_i & grp_hit & pending);
   assign wr_ok      = access & pwrite_i & ~err;
   assign commit_req = wr_ok & commit_hit & pwdata_i[0] & ~pending;
   assign apply      = pending & idle_i;

   for (genvar gi = 0; gi < 5; gi++) begin : g_we
      assign grp_we[gi] = wr_ok & grp_hit & (paddr_i[6:4] == 3'(gi));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= CS_IDLE;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= apply;
         case (state_reg)
            CS_IDLE:    if (commit_req) state_reg <= CS_PENDING;
            CS_PENDING: if (idle_i)     state_reg <= CS_IDLE;
            default:    state_reg <= CS_IDLE;
         endcase
      end
   end

   assign commit_pending_o = pending;
   assign commit_done_o    = done_reg;
   assign pready_o         = access;
   assign pslverr_o        = access & err;

   always_comb begin
      prdata_o = '0;
      if (access && !pwrite_i && !err) begin
         if (grp_hit) begin
            case (grp)
               FG_CAUSE: prdata_o = (sel == 2'd0) ? XLEN'(ctrl_rd[0]) : XLEN'(cause_rd);
               FG_TVEC:  prdata_o = (sel == 2'd0) ? XLEN'(ctrl_rd[1]) : {tvec_rd, 2'b00};
               FG_TVAL:  prdata_o = (sel == 2'd0) ? XLEN'(ctrl_rd[2]) : tval_rd;
               FG_PRIV:  prdata_o = (sel == 2'd0) ? XLEN'(ctrl_rd[3]) : XLEN'(priv_rd);
               FG_IADDR: prdata_o = (sel == 2'd0) ? XLEN'(ctrl_rd[4]) : iaddr_rd;
               default:  prdata_o = '0;
            endcase
         end else if (status_hit) begin
            prdata_o = XLEN'(pending);
         end
      end
   end

   trdb_filter_cfg_group #(.W(CAUSE_LEN)) u_cause (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(grp_we[0]), .sel_i(sel),
      .ctrl_wdata_i(pwdata_i[2:0]), .fld_wdata_i(pwdata_i[CAUSE_LEN-1:0]), .apply_i(apply),
      .ctrl_rd_o(ctrl_rd[0]), .fld_rd_o(cause_rd),
      .filter_o(cause_filter_o), .range_mode_o(cause_range_mode_o), .equal_mode_o(cause_equal_mode_o),
      .upper_o(upper_cause_o), .lower_o(lower_cause_o), .match_o(match_cause_o));

   trdb_filter_cfg_group #(.W(XLEN-2)) u_tvec (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(grp_we[1]), .sel_i(sel),
      .ctrl_wdata_i(pwdata_i[2:0]), .fld_wdata_i(pwdata_i[XLEN-1:2]), .apply_i(apply),
      .ctrl_rd_o(ctrl_rd[1]), .fld_rd_o(tvec_rd),
      .filter_o(tvec_filter_o), .range_mode_o(tvec_range_mode_o), .equal_mode_o(tvec_equal_mode_o),
      .upper_o(upper_tvec_o), .lower_o(lower_tvec_o), .match_o(match_tvec_o));

   trdb_filter_cfg_group #(.W(XLEN)) u_tval (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(grp_we[2]), .sel_i(sel),
      .ctrl_wdata_i(pwdata_i[2:0]), .fld_wdata_i(pwdata_i), .apply_i(apply),
      .ctrl_rd_o(ctrl_rd[2]), .fld_rd_o(tval_rd),
      .filter_o(tval_filter_o), .range_mode_o(tval_range_mode_o), .equal_mode_o(tval_equal_mode_o),
      .upper_o(upper_tval_o), .lower_o(lower_tval_o), .match_o(match_tval_o));

   trdb_filter_cfg_group #(.W(PRIV_LEN)) u_priv (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(grp_we[3]), .sel_i(sel),
      .ctrl_wdata_i(pwdata_i[2:0]), .fld_wdata_i(pwdata_i[PRIV_LEN-1:0]), .apply_i(apply),
      .ctrl_rd_o(ctrl_rd[3]), .fld_rd_o(priv_rd),
      .filter_o(priv_lvl_filter_o), .range_mode_o(priv_lvl_range_mode_o), .equal_mode_o(priv_lvl_equal_mode_o),
      .upper_o(upper_priv_lvl_o), .lower_o(lower_priv_lvl_o), .match_o(match_priv_lvl_o));

   trdb_filter_cfg_group #(.W(XLEN)) u_iaddr (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(grp_we[4]), .sel_i(sel),
      .ctrl_wdata_i(pwdata_i[2:0]), .fld_wdata_i(pwdata_i), .apply_i(apply),
      .ctrl_rd_o(ctrl_rd[4]), .fld_rd_o(iaddr_rd),
      .filter_o(iaddr_filter_o), .range_mode_o(iaddr_range_mode_o), .equal_mode_o(iaddr_equal_mode_o),
      .upper_o(upper_iaddr_o), .lower_o(lower_iaddr_o), .match_o(match_iaddr_o));

endmodule

// File: tb/tb_trdb_filter_regs.sv
// Testbench for trdb_filter_regs: directed steps followed by random APB
// traffic, checked against an array-based model of the register map.
module tb_trdb_filter_regs;
   import trdb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, psel, penable, pwrite, idle;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic pready, pslverr, pend_o, done_o;
   logic c_f, c_r, c_e, v_f, v_r, v_e, t_f, t_r, t_e, p_f, p_r, p_e, i_f, i_r, i_e;
   logic [CAUSE_LEN-1:0] c_u, c_l, c_m;
   logic [XLEN-1:2]      v_u, v_l, v_m;
   logic [XLEN-1:0]      t_u, t_l, t_m, i_u, i_l, i_m;
   logic [PRIV_LEN-1:0]  p_u, p_l, p_m;

   trdb_filter_regs #(.APB_ADDR_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
      .pslverr_o(pslverr), .idle_i(idle), .commit_pending_o(pend_o), .commit_done_o(done_o),
      .cause_filter_o(c_f), .cause_range_mode_o(c_r), .cause_equal_mode_o(c_e),
      .upper_cause_o(c_u), .lower_cause_o(c_l), .match_cause_o(c_m),
      .tvec_filter_o(v_f), .tvec_range_mode_o(v_r), .tvec_equal_mode_o(v_e),
      .upper_tvec_o(v_u), .lower_tvec_o(v_l), .match_tvec_o(v_m),
      .tval_filter_o(t_f), .tval_range_mode_o(t_r), .tval_equal_mode_o(t_e),
      .upper_tval_o(t_u), .lower_tval_o(t_l), .match_tval_o(t_m),
      .priv_lvl_filter_o(p_f), .priv_lvl_range_mode_o(p_r), .priv_lvl_equal_mode_o(p_e),
      .upper_priv_lvl_o(p_u), .lower_priv_lvl_o(p_l), .match_priv_lvl_o(p_m),
      .iaddr_filter_o(i_f), .iaddr_range_mode_o(i_r), .iaddr_equal_mode_o(i_e),
      .upper_iaddr_o(i_u), .lower_iaddr_o(i_l), .match_iaddr_o(i_m));

   int total = 0;
   int bad   = 0;

   // Model: shadow/active register images indexed [group][register]
   logic [31:0] sh [5][4];
   logic [31:0] act[5][4];
   bit pend, done_exp;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fmask(int g, int r);
      if (r == 0) return 32'h7;
      case (g)
         0:       return (32'd1 << CAUSE_LEN) - 1;
         1:       return 32'hFFFF_FFFC;
         3:       return (32'd1 << PRIV_LEN) - 1;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic bit is_mapped(logic [7:0] a);
      return (a[1:0] == 2'b00) && (a <= 8'h54);
   endfunction

   function automatic logic [31:0] model_read(logic [7:0] a);
      if (a < 8'h50) return sh[a / 16][(a % 16) / 4];
      if (a == 8'h54) return {31'd0, pend};
      return 32'd0;
   endfunction

   function automatic logic [31:0] pick(int r, logic [2:0] c, logic [31:0] u, logic [31:0] l, logic [31:0] m);
      case (r)
         0:       return {29'd0, c};
         1:       return u;
         2:       return l;
         default: return m;
      endcase
   endfunction

   function automatic logic [31:0] dut_out(int g, int r);
      case (g)
         0:       return pick(r, {c_e, c_r, c_f}, 32'(c_u), 32'(c_l), 32'(c_m));
         1:       return pick(r, {v_e, v_r, v_f}, {v_u, 2'b00}, {v_l, 2'b00}, {v_m, 2'b00});
         2:       return pick(r, {t_e, t_r, t_f}, t_u, t_l, t_m);
         3:       return pick(r, {p_e, p_r, p_f}, 32'(p_u), 32'(p_l), 32'(p_m));
         default: return pick(r, {i_e, i_r, i_f}, i_u, i_l, i_m);
      endcase
   endfunction

   // Effect of one clock edge on the model, from the bench's own drive values.
   task automatic model_edge();
      bit apply, nxt;
      int g, r;
      if (rst) begin
         for (int a = 0; a < 5; a++)
            for (int b = 0; b < 4; b++) begin
               sh[a][b]  = '0;
               act[a][b] = '0;
            end
         pend = 0;
         done_exp = 0;
         return;
      end
      apply = pend && idle;
      nxt = pend;
      if (apply) begin
         act = sh;
         nxt = 0;
      end
      if (psel && penable && pwrite && is_mapped(paddr) && !pend) begin
         if (paddr < 8'h50) begin
            g = paddr / 16;
            r = (paddr % 16) / 4;
            sh[g][r] = pwdata & fmask(g, r);
         end else if (paddr == 8'h50 && pwdata[0]) begin
            nxt = 1;
         end
      end
      pend = nxt;
      done_exp = apply;
   endtask

   task automatic check_state();
      chk("commit_pending", {31'd0, pend_o}, {31'd0, pend});
      chk("commit_done", {31'd0, done_o}, {31'd0, done_exp});
      for (int g = 0; g < 5; g++)
         for (int r = 0; r < 4; r++)
            chk($sformatf("active_g%0d_r%0d", g, r), dut_out(g, r), act[g][r]);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic apb(bit wr, logic [7:0] a, logic [31:0] d, output logic [31:0] rd, output logic err);
      logic [31:0] exp_rd;
      bit exp_err;
      psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
      #1;
      chk("setup_pready", {31'd0, pready}, 32'd0);
      chk("setup_pslverr", {31'd0, pslverr}, 32'd0);
      chk("setup_prdata", prdata, 32'd0);
      tick();
      penable = 1;
      exp_err = !is_mapped(a) || (wr && a == 8'h54) || (wr && a < 8'h50 && pend);
      exp_rd  = (wr || exp_err) ? 32'd0 : model_read(a);
      #1;
      chk($sformatf("pready_%h", a), {31'd0, pready}, 32'd1);
      chk($sformatf("pslverr_%h", a), {31'd0, pslverr}, {31'd0, exp_err});
      chk($sformatf("prdata_%h", a), prdata, exp_rd);
      rd = prdata;
      err = pslverr;
      tick();
      psel = 0; penable = 0; pwrite = 0;
   endtask

   logic [31:0] rd;
   logic err;
   int op;
   logic [7:0] a;

   initial begin
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; idle = 0;
      pend = 0; done_exp = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
      tick();

      // All 22 registers read back 0 after reset
      for (int k = 0; k < 22; k++) begin
         apb(0, 8'(k * 4), 32'd0, rd, err);
         chk("reset_read", rd, 32'd0);
         chk("reset_read_err", {31'd0, err}, 32'd0);
      end

      // Program cause group, commit while idle
      idle = 1;
      apb(1, 8'h00, 32'h3, rd, err);
      apb(1, 8'h04, 32'h1F, rd, err);
      apb(1, 8'h08, 32'h02, rd, err);
      apb(1, 8'h50, 32'h1, rd, err);
      chk("pend_at_commit_edge", {31'd0, pend_o}, 32'd1);
      chk("cause_filter_before_apply", {31'd0, c_f}, 32'd0);
      tick();
      chk("cause_filter_after_apply", {31'd0, c_f}, 32'd1);
      chk("cause_range_after_apply", {31'd0, c_r}, 32'd1);
      chk("upper_cause_after_apply", 32'(c_u), 32'h1F);
      chk("lower_cause_after_apply", 32'(c_l), 32'h02);
      chk("done_pulse", {31'd0, done_o}, 32'd1);
      tick();
      chk("done_pulse_end", {31'd0, done_o}, 32'd0);

      // Commit held off by busy encoder; shadow frozen
      idle = 0;
      apb(1, 8'h0C, 32'h15, rd, err);
      apb(1, 8'h50, 32'h1, rd, err);
      repeat (5) tick();
      chk("pend_while_busy", {31'd0, pend_o}, 32'd1);
      chk("match_cause_held", 32'(c_m), 32'd0);
      apb(1, 8'h24, 32'hDEAD_BEEF, rd, err);
      chk("write_while_pending_err", {31'd0, err}, 32'd1);
      apb(0, 8'h24, 32'd0, rd, err);
      chk("shadow_frozen", rd, 32'd0);
      idle = 1;
      tick();
      chk("match_cause_applied", 32'(c_m), 32'h15);
      tick();

      // tvec low bits
      apb(1, 8'h14, 32'hFFFF_FFFF, rd, err);
      apb(0, 8'h14, 32'd0, rd, err);
      chk("tvec_readback", rd, 32'hFFFF_FFFC);
      apb(1, 8'h50, 32'h1, rd, err);
      tick();
      chk("upper_tvec_ones", {v_u, 2'b11}, 32'hFFFF_FFFF);

      // Error cases and COMMIT with bit0=0
      apb(0, 8'h58, 32'd0, rd, err);
      chk("unmapped_err", {31'd0, err}, 32'd1);
      chk("unmapped_prdata", rd, 32'd0);
      apb(1, 8'h54, 32'h1, rd, err);
      chk("status_write_err", {31'd0, err}, 32'd1);
      apb(1, 8'h50, 32'h0, rd, err);
      chk("commit_bit0_clear", {31'd0, pend_o}, 32'd0);

      // Reset while pending
      idle = 0;
      apb(1, 8'h28, 32'h1234_5678, rd, err);
      apb(1, 8'h50, 32'h1, rd, err);
      rst = 1;
      tick();
      rst = 0;
      chk("rst_pend_clear", {31'd0, pend_o}, 32'd0);
      chk("rst_upper_cause", 32'(c_u), 32'd0);
      apb(0, 8'h28, 32'd0, rd, err);
      chk("rst_shadow_clear", rd, 32'd0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         idle = ($urandom_range(0, 2) != 0);
         op = $urandom_range(0, 99);
         if (op < 45) begin
            a = 8'($urandom_range(0, 19) * 4);
            apb(1, a, $urandom, rd, err);
         end else if (op < 70) begin
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 23) * 4);
            apb(0, a, 32'd0, rd, err);
         end else if (op < 85) begin
            apb(1, 8'h50, 32'($urandom_range(0, 1)), rd, err);
         end else begin
            repeat ($urandom_range(1, 3)) tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
